score_event_serializer: RTL and testbench

- Sits directly upstream of the score counter, between the collision/kill logic and the score block's three event inputs.
- The score block collapses events that arrive in the same cycle into one add, and its digit carry ripples one digit per cycle. Both effects lose points.
- This block queues kill events per type and replays them one at a time, spaced far enough apart that each carry finishes settling before the next add.

---
 rtl/score_event_serializer_pkg.sv | 37 +++
 rtl/score_event_serializer_counter.sv | 35 +++
 rtl/score_event_serializer.sv | 136 +++++++++++++
 tb/tb_score_event_serializer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/score_event_serializer_pkg.sv
// Shared types and constants for the kill-event serializer in front of the score counter.
package score_event_serializer_pkg;

  // Replay FSM: IDLE picks the next pending event, GAP waits for the score carry to settle
  typedef enum logic {
    IDLE,
    GAP
  } state_t;

  // Kill event types, listed in replay priority order
  typedef enum logic [1:0] {
    EV_BOSS,
    EV_MONSTER,
    EV_ASTEROID
  } ev_t;

  // The score digit carry needs this many quiet cycles to settle after an add
  localparam int SCORE_DIGIT_AMOUNT = 3;
  localparam int DEFAULT_GAP_CYCLES = SCORE_DIGIT_AMOUNT;

  // Width of the gap counter, enough for the largest legal gap of 15
  localparam int GAP_W = 4;

  // Fixed priority pick; only meaningful when at least one type is pending
  function automatic ev_t select_event(input logic boss_nz, input logic monster_nz);
    ev_t sel;
    if (boss_nz) begin
      sel = EV_BOSS;
    end else if (monster_nz) begin
      sel = EV_MONSTER;
    end else begin
      sel = EV_ASTEROID;
    end
    return sel;
  endfunction

endpackage

// File: rtl/score_event_serializer_counter.sv
// Saturating pending-event counter, one instance per kill event type.
module sat_event_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             sat_drop
);

  localparam logic [CNT_W-1:0] MAX_COUNT = '1;

  assign nonzero  = (count != '0);
  assign sat_drop = inc && !dec && !clr && (count == MAX_COUNT);

  // Clear wins, a simultaneous inc and dec cancel, and an inc at max is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      if (count != MAX_COUNT) begin
        count <= count + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/score_event_serializer.sv
// Queues kill events per type and replays them one at a time, spaced for the score carry.
module score_event_serializer
  import score_event_serializer_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic monster_died_pulse_in,
  input  logic boss_died_pulse_in,
  input  logic asteroid_exploded_pulse_in,
  output logic monster_died_pulse,
  output logic boss_died_pulse,
  output logic asteroid_exploded_pulse,
  output logic busy,
  output logic overflow
);

  state_t           state;
  state_t           state_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_next;
  ev_t              sel;
  logic             dec_boss;
  logic             dec_monster;
  logic             dec_asteroid;
  logic             boss_nz;
  logic             monster_nz;
  logic             asteroid_nz;
  logic             boss_drop;
  logic             monster_drop;
  logic             asteroid_drop;
  logic [CNT_W-1:0] boss_count;
  logic [CNT_W-1:0] monster_count;
  logic [CNT_W-1:0] asteroid_count;
  logic             can_issue;

  sat_event_counter #(.CNT_W(CNT_W)) u_boss_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (boss_died_pulse_in),
    .dec      (dec_boss),
    .clr      (flush),
    .count    (boss_count),
    .nonzero  (boss_nz),
    .sat_drop (boss_drop)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_monster_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (monster_died_pulse_in),
    .dec      (dec_monster),
    .clr      (flush),
    .count    (monster_count),
    .nonzero  (monster_nz),
    .sat_drop (monster_drop)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_asteroid_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (asteroid_exploded_pulse_in),
    .dec      (dec_asteroid),
    .clr      (flush),
    .count    (asteroid_count),
    .nonzero  (asteroid_nz),
    .sat_drop (asteroid_drop)
  );

  // The last GAP cycle (gap counter at 0) may already issue, so pulses land GAP_CYCLES+1 apart
  assign can_issue = (state == IDLE) || (gap_cnt == '0);

  assign busy = (state != IDLE) || (boss_count != '0) || (monster_count != '0) ||
                (asteroid_count != '0);

  // Next-state logic: pick one pending type by priority, then count down the gap
  always_comb begin
    state_next   = state;
    gap_next     = gap_cnt;
    sel          = EV_BOSS;
    dec_boss     = 1'b0;
    dec_monster  = 1'b0;
    dec_asteroid = 1'b0;
    if (flush) begin
      state_next = IDLE;
      gap_next   = '0;
    end else if (can_issue) begin
      if (boss_nz || monster_nz || asteroid_nz) begin
        sel = select_event(boss_nz, monster_nz);
        unique case (sel)
          EV_BOSS:     dec_boss     = 1'b1;
          EV_MONSTER:  dec_monster  = 1'b1;
          EV_ASTEROID: dec_asteroid = 1'b1;
          default:     dec_boss     = 1'b0;
        endcase
        state_next = GAP;
        gap_next   = GAP_W'(GAP_CYCLES);
      end else begin
        state_next = IDLE;
        gap_next   = '0;
      end
    end else begin
      gap_next = gap_cnt - GAP_W'(1);
    end
  end

  // State, gap counter and registered one-cycle output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      gap_cnt                 <= '0;
      boss_died_pulse         <= 1'b0;
      monster_died_pulse      <= 1'b0;
      asteroid_exploded_pulse <= 1'b0;
    end else begin
      state                   <= state_next;
      gap_cnt                 <= gap_next;
      boss_died_pulse         <= dec_boss;
      monster_died_pulse      <= dec_monster;
      asteroid_exploded_pulse <= dec_asteroid;
    end
  end

  // Sticky flag for any event lost to a saturated counter
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (boss_drop || monster_drop || asteroid_drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_event_serializer.sv
// Directed bench for score_event_serializer with hand-computed pulse timing.
module tb_score_event_serializer;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic monster_in;
  logic boss_in;
  logic asteroid_in;
  logic monster_died_pulse;
  logic boss_died_pulse;
  logic asteroid_exploded_pulse;
  logic busy;
  logic overflow;

  int tests_run    = 0;
  int tests_failed = 0;
  int boss_seen     = 0;
  int monster_seen  = 0;
  int asteroid_seen = 0;
  int overlap_seen  = 0;
  int wide_seen     = 0;
  logic prev_any    = 1'b0;

  int b0;
  int m0;
  int a0;

  always #5 clk = ~clk;

  score_event_serializer #(
    .CNT_W      (4),
    .GAP_CYCLES (3)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .flush                      (flush),
    .monster_died_pulse_in      (monster_in),
    .boss_died_pulse_in         (boss_in),
    .asteroid_exploded_pulse_in (asteroid_in),
    .monster_died_pulse         (monster_died_pulse),
    .boss_died_pulse            (boss_died_pulse),
    .asteroid_exploded_pulse    (asteroid_exploded_pulse),
    .busy                       (busy),
    .overflow                   (overflow)
  );

  // Mid-cycle monitor tallying pulses, overlaps and pulses wider than one cycle
  always @(negedge clk) begin
    if (boss_died_pulse === 1'b1) boss_seen <= boss_seen + 1;
    if (monster_died_pulse === 1'b1) monster_seen <= monster_seen + 1;
    if (asteroid_exploded_pulse === 1'b1) asteroid_seen <= asteroid_seen + 1;
    if ((int'(boss_died_pulse === 1'b1) + int'(monster_died_pulse === 1'b1) +
         int'(asteroid_exploded_pulse === 1'b1)) > 1) overlap_seen <= overlap_seen + 1;
    if (prev_any && ((boss_died_pulse | monster_died_pulse | asteroid_exploded_pulse) === 1'b1))
      wide_seen <= wide_seen + 1;
    prev_any <= ((boss_died_pulse | monster_died_pulse | asteroid_exploded_pulse) === 1'b1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs, then land one cycle later with inputs released
  task automatic applyStimulus(input logic b, input logic m, input logic a, input logic f);
    boss_in     = b;
    monster_in  = m;
    asteroid_in = a;
    flush       = f;
    step();
    boss_in     = 1'b0;
    monster_in  = 1'b0;
    asteroid_in = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    checkOutput({tag, "_drained"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic snapshot();
    b0 = boss_seen;
    m0 = monster_seen;
    a0 = asteroid_seen;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset       = 1'b1;
    flush       = 1'b0;
    monster_in  = 1'b0;
    boss_in     = 1'b0;
    asteroid_in = 1'b0;
    step();
    step();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_overflow", {31'd0, overflow}, 32'd0);
    checkOutput("reset_pulses",
                {29'd0, boss_died_pulse, monster_died_pulse, asteroid_exploded_pulse}, 32'd0);
    reset = 1'b0;
    step();
    step();
    checkOutput("idle_busy", {31'd0, busy}, 32'd0);

    // Single monster: pulse two cycles after the input, busy for five cycles
    snapshot();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      checkOutput($sformatf("t1_monster_c%0d", k), {31'd0, monster_died_pulse}, (k == 2) ? 1 : 0);
      checkOutput($sformatf("t1_busy_c%0d", k), {31'd0, busy}, (k <= 5) ? 1 : 0);
      if (k < 6) step();
    end
    checkOutput("t1_monster_count", monster_seen - m0, 1);
    checkOutput("t1_boss_count", boss_seen - b0, 0);
    checkOutput("t1_asteroid_count", asteroid_seen - a0, 0);

    // All three at once: boss, monster, asteroid four cycles apart
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      checkOutput($sformatf("t2_boss_c%0d", k), {31'd0, boss_died_pulse}, (k == 2) ? 1 : 0);
      checkOutput($sformatf("t2_monster_c%0d", k), {31'd0, monster_died_pulse},
                  (k == 6) ? 1 : 0);
      checkOutput($sformatf("t2_asteroid_c%0d", k), {31'd0, asteroid_exploded_pulse},
                  (k == 10) ? 1 : 0);
      if (k < 14) step();
    end
    checkOutput("t2_busy_end", {31'd0, busy}, 32'd0);

    // Monster inputs that coincide with monster issues: five in, five out
    snapshot();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    waitIdle(100, "t4");
    checkOutput("t4_monster_count", monster_seen - m0, 5);
    checkOutput("t4_overflow", {31'd0, overflow}, 32'd0);

    // Twenty cycles of all three: boss hogs the issue slots, asteroid and monster saturate at 15
    snapshot();
    for (int j = 0; j < 20; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("t3_overflow_c%0d", j + 1), {31'd0, overflow}, (j >= 15) ? 1 : 0);
    end
    waitIdle(400, "t3");
    checkOutput("t3_boss_count", boss_seen - b0, 20);
    checkOutput("t3_monster_count", monster_seen - m0, 15);
    checkOutput("t3_asteroid_count", asteroid_seen - a0, 15);
    checkOutput("t3_overflow_sticky", {31'd0, overflow}, 32'd1);

    // Flush mid-gap with three monsters pending; asteroid in the flush cycle is discarded
    snapshot();
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_first_issue", monster_seen - m0, 1);
    checkOutput("t5_busy_before", {31'd0, busy}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("t5_pulses_after",
                {29'd0, boss_died_pulse, monster_died_pulse, asteroid_exploded_pulse}, 32'd0);
    checkOutput("t5_overflow_kept", {31'd0, overflow}, 32'd1);
    snapshot();
    repeat (12) step();
    checkOutput("t5_no_monster", monster_seen - m0, 0);
    checkOutput("t5_no_asteroid", asteroid_seen - a0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("t5_fresh_c1", {31'd0, boss_died_pulse}, 32'd0);
    step();
    checkOutput("t5_fresh_c2", {31'd0, boss_died_pulse}, 32'd1);
    waitIdle(20, "t5");

    // Reset during GAP with two monsters pending clears everything including overflow
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("t6_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("t6_overflow_after", {31'd0, overflow}, 32'd0);
    checkOutput("t6_pulses_after",
                {29'd0, boss_died_pulse, monster_died_pulse, asteroid_exploded_pulse}, 32'd0);
    snapshot();
    repeat (12) step();
    checkOutput("t6_no_pulses", (boss_seen - b0) + (monster_seen - m0) + (asteroid_seen - a0), 0);
    checkOutput("t6_busy_idle", {31'd0, busy}, 32'd0);

    checkOutput("overlap_cycles", overlap_seen, 0);
    checkOutput("wide_pulses", wide_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
